trng_conditioner: RTL

TRNG_CONDITIONER -- requirements
Module: trng_conditioner

---
 rtl/trng_conditioner.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/trng_conditioner.sv
// Von Neumann debiaser with a repetition-count health test, feeding an 8-bit packer and a byte FIFO.
// A health failure flushes all buffered entropy and holds output off until clr_fail.
module trng_conditioner #(
  parameter int FIFO_DEPTH = 4,
  parameter int RCT_LIMIT  = 31
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       raw_bit,
  input  logic       raw_valid,
  input  logic       clr_fail,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       health_fail,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {FIRST, SECOND, FAIL} state_t;

  state_t          state_q, state_d;
  logic            pair_q, pair_d;
  logic [7:0]      pack_q, pack_d;
  logic [2:0]      fill_q, fill_d;
  logic [7:0]      run_q, run_d;
  logic            prev_q, prev_d;
  logic            have_q, have_d;
  logic            hf_q, hf_d;
  logic            ovf_q, ovf_d;
  logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            emit, emit_bit, push, pop, wr_en, flush;
  logic [7:0]      push_byte;

  assign out_valid   = (cnt_q != '0);
  assign out_data    = out_valid ? mem_q[rd_q] : 8'h00;
  assign health_fail = hf_q;
  assign overflow    = ovf_q;

  always_comb begin
    state_d   = state_q;
    pair_d    = pair_q;
    pack_d    = pack_q;
    fill_d    = fill_q;
    run_d     = run_q;
    prev_d    = prev_q;
    have_d    = have_q;
    hf_d      = hf_q;
    ovf_d     = ovf_q;
    wr_d      = wr_q;
    rd_d      = rd_q;
    cnt_d     = cnt_q;
    emit      = 1'b0;
    emit_bit  = 1'b0;
    push      = 1'b0;
    wr_en     = 1'b0;
    flush     = 1'b0;
    pop       = out_valid & out_ready;

    case (state_q)
      FIRST, SECOND: begin
        if (raw_valid) begin
          run_d  = (have_q && raw_bit == prev_q) ? run_q + 8'd1 : 8'd1;
          prev_d = raw_bit;
          have_d = 1'b1;
          if (state_q == FIRST) begin
            pair_d  = raw_bit;
            state_d = SECOND;
          end else begin
            state_d = FIRST;
            // 1,0 -> 1 and 0,1 -> 0: the emitted bit is the first of the pair
            if (pair_q != raw_bit) begin
              emit     = 1'b1;
              emit_bit = pair_q;
            end
          end
          if (run_d == 8'(RCT_LIMIT)) begin
            state_d = FAIL;
            hf_d    = 1'b1;
            flush   = 1'b1;
            emit    = 1'b0;
          end
        end
      end
      default: begin
        if (clr_fail) begin
          state_d = FIRST;
          hf_d    = 1'b0;
          run_d   = 8'd0;
          prev_d  = 1'b0;
          have_d  = 1'b0;
        end
      end
    endcase

    push_byte = {pack_q[6:0], emit_bit};
    if (emit) begin
      if (fill_q == 3'd7) begin
        push   = 1'b1;
        pack_d = 8'h00;
        fill_d = 3'd0;
      end else begin
        pack_d = push_byte;
        fill_d = fill_q + 3'd1;
      end
    end

    if (flush) begin
      pack_d = 8'h00;
      fill_d = 3'd0;
      pair_d = 1'b0;
      wr_d   = '0;
      rd_d   = '0;
      cnt_d  = '0;
    end else begin
      if (push) begin
        if (cnt_q == (AW+1)'(FIFO_DEPTH) && !pop) ovf_d = 1'b1;
        else wr_en = 1'b1;
      end
      if (wr_en) wr_d = wr_q + AW'(1);
      if (pop)   rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FIRST;
      pair_q  <= 1'b0;
      pack_q  <= 8'h00;
      fill_q  <= 3'd0;
      run_q   <= 8'd0;
      prev_q  <= 1'b0;
      have_q  <= 1'b0;
      hf_q    <= 1'b0;
      ovf_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pair_q  <= pair_d;
      pack_q  <= pack_d;
      fill_q  <= fill_d;
      run_q   <= run_d;
      prev_q  <= prev_d;
      have_q  <= have_d;
      hf_q    <= hf_d;
      ovf_q   <= ovf_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy gates what is visible.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_q] <= push_byte;
  end
endmodule
